instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/baluga_isa_pkg.sv | 18 +
 rtl/instruction_fetch.sv | 139 +++++++++++++
 tb/tb_instruction_fetch.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/baluga_isa_pkg.sv
// Shared ISA definitions for the baluga core: widths, the HALT opcode and
// the fetch-unit state encoding.
package baluga_isa_pkg;

  localparam int ISA_PC_WIDTH    = 8;
  localparam int ISA_INSTR_WIDTH = 9;

  // Opcode 0111, mode 00, function 010 stops the fetch stream.
  localparam logic [ISA_INSTR_WIDTH-1:0] ISA_HALT_INSTR = 9'b0111_00_010;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_HALT_PEND = 2'd2,
    ST_HALTED    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: walks a combinational ROM by program counter and
// hands one instruction at a time to decode through a single-entry output
// register. Supports stalls, branch redirects and a HALT instruction.
//
// Handshake: instr_valid/instr_ready follow strict valid/ready rules. While
// instr_valid is high, instr_out and instr_pc stay stable until a cycle with
// instr_ready high (the transfer). instr_valid never depends on instr_ready
// in the same cycle. A redirect cancels the held instruction: that cycle
// counts as no transfer even if instr_ready is high.
module instruction_fetch
  import baluga_isa_pkg::*;
#(
  parameter int PC_WIDTH    = ISA_PC_WIDTH,
  parameter int INSTR_WIDTH = ISA_INSTR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  output logic [PC_WIDTH-1:0]    rom_address,
  input  logic [INSTR_WIDTH-1:0] rom_instruction,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  output logic                   halted,
  output logic [15:0]            fetch_count,
  output fetch_state_t           state_dbg
);

  localparam logic [INSTR_WIDTH-1:0] HALT_WORD = INSTR_WIDTH'(ISA_HALT_INSTR);
  localparam logic [PC_WIDTH-1:0]    PC_ONE    = PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0]    PC_ZERO   = '0;

  fetch_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;
  logic [15:0]            count_q, count_d;

  logic consume;

  // A transfer to decode that is not cancelled by a redirect.
  assign consume = valid_q && instr_ready && !redirect;

  // Next-state and datapath control for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    count_d    = count_q;

    if (consume && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        // redirect is deliberately ignored while not fetching
        if (start) begin
          pc_d     = PC_ZERO;
          count_d  = 16'd0;
          halted_d = 1'b0;
          valid_d  = 1'b0;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        if (redirect) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
        end else if (!valid_q || instr_ready) begin
          instr_d    = rom_instruction;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          // pc freezes on HALT so nothing past it is ever fetched
          if (rom_instruction == HALT_WORD) begin
            state_d = ST_HALT_PEND;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end

      ST_HALT_PEND: begin
        if (redirect) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
          state_d = ST_RUN;
        end else if (instr_ready) begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = ST_HALTED;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
    end
  end

  assign rom_address = pc_q;
  assign instr_out   = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural ROM.
module tb_instruction_fetch;
  import baluga_isa_pkg::*;

  localparam logic [8:0] HALT_W = 9'b0111_00_010;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [7:0]   rom_address;
  logic [8:0]   rom_instruction;
  logic [8:0]   instr_out;
  logic [7:0]   instr_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic         redirect;
  logic [7:0]   redirect_target;
  logic         halted;
  logic [15:0]  fetch_count;
  fetch_state_t state_dbg;

  logic [8:0] rom_mem [256];
  int n_checks;
  int n_pass;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign rom_instruction = rom_mem[rom_address];

  instruction_fetch #(.PC_WIDTH(8), .INSTR_WIDTH(9)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halted          (halted),
    .fetch_count     (fetch_count),
    .state_dbg       (state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic fill_rom_identity();
    for (int i = 0; i < 256; i++) rom_mem[i] = 9'(i);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_out"},   32'(instr_out),   32'd0);
    check({tag, "_ipc"},   32'(instr_pc),    32'd0);
    check({tag, "_addr"},  32'(rom_address), 32'd0);
    check({tag, "_halt"},  32'(halted),      32'd0);
    check({tag, "_cnt"},   32'(fetch_count), 32'd0);
    check({tag, "_state"}, 32'(state_dbg),   32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_target = 8'h00;
    fill_rom_identity();

    // Reset state
    step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    // Sequential fetch, ROM word[n] = n
    pulse_start();
    check("start_state", 32'(state_dbg), 32'(ST_RUN));
    check("start_valid", 32'(instr_valid), 32'd0);
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("seq_out%0d", k), 32'(instr_out), 32'(k));
      check($sformatf("seq_pc%0d", k),  32'(instr_pc),  32'(k));
      check($sformatf("seq_cnt%0d", k), 32'(fetch_count), 32'(k));
    end

    // Stall at instr_pc=5 for three cycles
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall_out%0d", k),  32'(instr_out),   32'd5);
      check($sformatf("stall_ipc%0d", k),  32'(instr_pc),    32'd5);
      check($sformatf("stall_addr%0d", k), 32'(rom_address), 32'd6);
      check($sformatf("stall_cnt%0d", k),  32'(fetch_count), 32'd5);
    end
    instr_ready = 1'b1;
    step();
    check("resume_out", 32'(instr_out),   32'd6);
    check("resume_cnt", 32'(fetch_count), 32'd6);

    // Run up to instr_pc=0x24, then redirect to 0x07
    for (int k = 0; k < 30; k++) step();
    check("pre_redir_ipc", 32'(instr_pc),    32'h24);
    check("pre_redir_cnt", 32'(fetch_count), 32'd36);
    redirect = 1'b1; redirect_target = 8'h07;
    step();
    redirect = 1'b0;
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_addr",  32'(rom_address), 32'h07);
    check("redir_cnt",   32'(fetch_count), 32'd36);
    step();
    check("redir_ipc",   32'(instr_pc),    32'h07);
    check("redir_out",   32'(instr_out),   32'h07);
    check("redir_v2",    32'(instr_valid), 32'd1);
    step();
    check("redir_cnt2",  32'(fetch_count), 32'd37);

    // HALT at address 42
    instr_ready = 1'b0;
    do_reset();
    rom_mem[42] = HALT_W;
    pulse_start();
    instr_ready = 1'b1;
    for (int k = 0; k < 43; k++) step();
    check("halt_out",   32'(instr_out),   32'(HALT_W));
    check("halt_ipc",   32'(instr_pc),    32'd42);
    check("halt_state", 32'(state_dbg),   32'(ST_HALT_PEND));
    check("halt_addr",  32'(rom_address), 32'd42);
    check("halt_h0",    32'(halted),      32'd0);
    check("halt_cnt0",  32'(fetch_count), 32'd42);
    step();
    check("halt_h1",    32'(halted),      32'd1);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_cnt1",  32'(fetch_count), 32'd43);
    check("halt_st2",   32'(state_dbg),   32'(ST_HALTED));
    // redirect must be ignored once halted
    redirect = 1'b1; redirect_target = 8'h03;
    step();
    step();
    redirect = 1'b0;
    check("halted_addr",  32'(rom_address), 32'd42);
    check("halted_h",     32'(halted),      32'd1);
    check("halted_valid", 32'(instr_valid), 32'd0);
    check("halted_cnt",   32'(fetch_count), 32'd43);

    // Restart from HALTED; HALT at 3 cancelled by redirect to 0x1A
    rom_mem[42] = 9'd42;
    rom_mem[3]  = HALT_W;
    pulse_start();
    check("restart_h",   32'(halted),      32'd0);
    check("restart_cnt", 32'(fetch_count), 32'd0);
    check("restart_st",  32'(state_dbg),   32'(ST_RUN));
    for (int k = 0; k < 4; k++) step();
    check("hp_out",   32'(instr_out),   32'(HALT_W));
    check("hp_ipc",   32'(instr_pc),    32'd3);
    check("hp_state", 32'(state_dbg),   32'(ST_HALT_PEND));
    check("hp_cnt",   32'(fetch_count), 32'd3);
    redirect = 1'b1; redirect_target = 8'h1A;
    step();
    redirect = 1'b0;
    check("hpr_h",     32'(halted),      32'd0);
    check("hpr_valid", 32'(instr_valid), 32'd0);
    check("hpr_addr",  32'(rom_address), 32'h1A);
    check("hpr_state", 32'(state_dbg),   32'(ST_RUN));
    check("hpr_cnt",   32'(fetch_count), 32'd3);
    step();
    check("hpr_ipc",   32'(instr_pc),    32'h1A);
    check("hpr_out",   32'(instr_out),   32'h1A);
    check("hpr_v1",    32'(instr_valid), 32'd1);
    rom_mem[3] = 9'd3;

    // PC wrap with all-zero ROM, then asynchronous reset mid-stall
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 256; i++) rom_mem[i] = 9'd0;
    pulse_start();
    instr_ready = 1'b1;
    for (int k = 0; k < 256; k++) step();
    check("wrap_ipc255", 32'(instr_pc),    32'hFF);
    check("wrap_addr0",  32'(rom_address), 32'h00);
    step();
    check("wrap_ipc0",   32'(instr_pc),    32'h00);
    check("wrap_cnt",    32'(fetch_count), 32'd256);
    instr_ready = 1'b0;
    step();
    check("wrap_stall_v", 32'(instr_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    reset_n = 1'b1;
    step();
    check("post_rst_valid", 32'(instr_valid), 32'd0);
    check("post_rst_state", 32'(state_dbg),   32'(ST_IDLE));
    // redirect ignored in IDLE
    redirect = 1'b1; redirect_target = 8'h55;
    step();
    redirect = 1'b0;
    check("idle_redir_addr", 32'(rom_address), 32'h00);
    check("idle_redir_v",    32'(instr_valid), 32'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
